// File: rtl/wt_store_credit_ctrl_pkg.sv
// Shared types and sizing helpers for the store-issue throttle.
package wt_store_credit_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      NI_WAIT = 2'd1,
      DRAIN   = 2'd2
   } store_ctrl_state_e;

   localparam int unsigned MaxOutstandingStoresDefault = 7;

   // Width needed to hold every value in 0..max_val inclusive.
   function automatic int unsigned cnt_width(input int unsigned max_val);
      return $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/wt_store_credit_ctrl_sat_updown_cnt.sv
// Up/down counter clamped to 0..MAX that also flags decrements attempted at 0.
module sat_updown_cnt
   import wt_store_credit_ctrl_pkg::*;
#(
   parameter int unsigned MAX = 7
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic                        inc_i,
   input  logic                        dec_i,
   output logic [$clog2(MAX+1)-1:0]    cnt_o,
   output logic                        underflow_o
);

   localparam int unsigned   CW     = cnt_width(MAX);
   localparam logic [CW-1:0] MaxVal = CW'(MAX);

   logic [CW-1:0] cnt_reg;
   logic [CW-1:0] cnt_next;
   logic          dec_ok;

   // A decrement only takes effect when there is something to remove.
   assign dec_ok = dec_i && (cnt_reg != '0);

   always_comb begin
      cnt_next = cnt_reg;
      if (inc_i && !dec_ok) begin
         if (cnt_reg != MaxVal) begin
            cnt_next = cnt_reg + 1'b1;
         end
      end else if (!inc_i && dec_ok) begin
         cnt_next = cnt_reg - 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_reg <= '0;
      end else begin
         cnt_reg <= cnt_next;
      end
   end

   assign cnt_o       = cnt_reg;
   assign underflow_o = dec_i && (cnt_reg == '0);

endmodule

// File: rtl/wt_store_credit_ctrl.sv
// Store-issue throttle: caps in-flight stores, serialises non-idempotent stores, drains on fence.
module wt_store_credit_ctrl
   import wt_store_credit_ctrl_pkg::*;
#(
   parameter int unsigned MaxOutstanding = MaxOutstandingStoresDefault
) (
   input  logic                                clk_i,
   input  logic                                rst_ni,
   input  logic                                flush_i,
   input  logic                                st_req_i,
   input  logic                                st_nonidem_i,
   output logic                                st_gnt_o,
   input  logic                                st_ack_i,
   input  logic                                fence_i,
   output logic                                fence_done_o,
   output logic                                no_st_pending_o,
   output logic [$clog2(MaxOutstanding+1)-1:0] outstanding_o,
   output logic                                ack_err_o
);

   localparam int unsigned     CntW   = cnt_width(MaxOutstanding);
   localparam logic [CntW-1:0] MaxCnt = CntW'(MaxOutstanding);
   localparam logic [CntW-1:0] OneCnt = CntW'(1);

   store_ctrl_state_e state_reg;
   store_ctrl_state_e state_next;
   logic [CntW-1:0]   cnt;
   logic              gnt;
   logic              fence_done;
   logic              underflow;
   logic              ni_clear;
   logic              ack_err_reg;

   sat_updown_cnt #(
      .MAX (MaxOutstanding)
   ) u_cnt (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .inc_i       (st_gnt_o),
      .dec_i       (st_ack_i),
      .cnt_o       (cnt),
      .underflow_o (underflow)
   );

   // No grants happen in NI_WAIT, so the count reaches zero next cycle
   // either because it already is zero or because the last store is acked now.
   assign ni_clear = (cnt == '0) || ((cnt == OneCnt) && st_ack_i);

   always_comb begin
      gnt        = 1'b0;
      fence_done = 1'b0;
      state_next = state_reg;
      if (flush_i) begin
         state_next = RUN;
      end else begin
         unique case (state_reg)
            RUN: begin
               if (fence_i) begin
                  state_next = DRAIN;
               end else if (st_req_i && !st_nonidem_i) begin
                  gnt = (cnt < MaxCnt);
               end else if (st_req_i && st_nonidem_i && (cnt == '0)) begin
                  gnt        = 1'b1;
                  state_next = NI_WAIT;
               end
            end
            NI_WAIT: begin
               if (ni_clear) begin
                  state_next = RUN;
               end
            end
            DRAIN: begin
               if (cnt == '0) begin
                  fence_done = 1'b1;
                  state_next = RUN;
               end
            end
            default: state_next = RUN;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_reg   <= RUN;
         ack_err_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         if (underflow) begin
            ack_err_reg <= 1'b1;
         end
      end
   end

   // The grant is combinational, so it has to be masked explicitly while reset is held.
   assign st_gnt_o        = gnt && rst_ni;
   assign fence_done_o    = fence_done;
   assign no_st_pending_o = (cnt == '0);
   assign outstanding_o   = cnt;
   assign ack_err_o       = ack_err_reg;

endmodule

// File: tb/tb_wt_store_credit_ctrl.sv
// Directed and randomized checks of the store throttle against a transaction-level model.
module tb_wt_store_credit_ctrl;

   localparam int unsigned MAX = 7;

   logic       clk_i        = 1'b0;
   logic       rst_ni       = 1'b0;
   logic       flush_i      = 1'b0;
   logic       st_req_i     = 1'b0;
   logic       st_nonidem_i = 1'b0;
   logic       st_ack_i     = 1'b0;
   logic       fence_i      = 1'b0;
   logic       st_gnt_o;
   logic       fence_done_o;
   logic       no_st_pending_o;
   logic [2:0] outstanding_o;
   logic       ack_err_o;

   int checks   = 0;
   int failures = 0;

   // Model: stores in flight, NI store awaiting ack, fence draining, sticky error.
   int m_cnt   = 0;
   bit m_ni    = 1'b0;
   bit m_drain = 1'b0;
   bit m_err   = 1'b0;

   bit g_gnt;
   bit g_done;
   int gnt_total  = 0;
   int done_total = 0;

   wt_store_credit_ctrl #(
      .MaxOutstanding (MAX)
   ) dut (
      .clk_i           (clk_i),
      .rst_ni          (rst_ni),
      .flush_i         (flush_i),
      .st_req_i        (st_req_i),
      .st_nonidem_i    (st_nonidem_i),
      .st_gnt_o        (st_gnt_o),
      .st_ack_i        (st_ack_i),
      .fence_i         (fence_i),
      .fence_done_o    (fence_done_o),
      .no_st_pending_o (no_st_pending_o),
      .outstanding_o   (outstanding_o),
      .ack_err_o       (ack_err_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // One cycle: drive at negedge, check just before posedge, advance the model.
   task automatic step(input bit req, input bit ni, input bit ack, input bit fence, input bit flush);
      bit e_gnt;
      bit e_done;
      int dec;
      st_req_i     = req;
      st_nonidem_i = ni;
      st_ack_i     = ack;
      fence_i      = fence;
      flush_i      = flush;
      #2;
      e_done = m_drain && (m_cnt == 0) && !flush;
      e_gnt  = req && !flush && !fence && !m_drain && !m_ni &&
               (ni ? (m_cnt == 0) : (m_cnt < int'(MAX)));
      chk("st_gnt", 32'(st_gnt_o), 32'(e_gnt));
      chk("fence_done", 32'(fence_done_o), 32'(e_done));
      chk("outstanding", 32'(outstanding_o), 32'(m_cnt));
      chk("no_pending", 32'(no_st_pending_o), 32'(m_cnt == 0));
      chk("ack_err", 32'(ack_err_o), 32'(m_err));
      g_gnt      = st_gnt_o;
      g_done     = fence_done_o;
      gnt_total  += int'(st_gnt_o);
      done_total += int'(fence_done_o);
      @(posedge clk_i);
      if (ack && m_cnt == 0) m_err = 1'b1;
      dec   = (ack && m_cnt > 0) ? 1 : 0;
      m_cnt = m_cnt + int'(e_gnt) - dec;
      if (flush) begin
         m_ni    = 1'b0;
         m_drain = 1'b0;
      end else if (m_drain) begin
         if (e_done) m_drain = 1'b0;
      end else if (m_ni) begin
         if (m_cnt == 0) m_ni = 1'b0;
      end else if (fence) begin
         m_drain = 1'b1;
      end else if (e_gnt && ni) begin
         m_ni = 1'b1;
      end
      @(negedge clk_i);
   endtask

   task automatic do_reset(input bit req);
      rst_ni       = 1'b0;
      st_req_i     = req;
      st_nonidem_i = 1'b0;
      st_ack_i     = 1'b0;
      fence_i      = 1'b0;
      flush_i      = 1'b0;
      #2;
      chk("rst_outstanding", 32'(outstanding_o), 32'd0);
      chk("rst_gnt", 32'(st_gnt_o), 32'd0);
      chk("rst_no_pending", 32'(no_st_pending_o), 32'd1);
      chk("rst_ack_err", 32'(ack_err_o), 32'd0);
      chk("rst_done", 32'(fence_done_o), 32'd0);
      m_cnt   = 0;
      m_ni    = 1'b0;
      m_drain = 1'b0;
      m_err   = 1'b0;
      @(negedge clk_i);
      rst_ni = 1'b1;
   endtask

   initial begin
      bit f_lvl;
      bit fl;
      bit rq;
      bit nq;
      bit ak;

      @(negedge clk_i);
      do_reset(1'b1);

      // Burst to the cap, then one ack frees exactly one slot.
      gnt_total = 0;
      for (int i = 0; i < 10; i++) step(1, 0, 0, 0, 0);
      chk("burst_grants", 32'(gnt_total), 32'd7);
      chk("burst_full", 32'(outstanding_o), 32'd7);
      step(1, 0, 1, 0, 0);
      chk("burst_no_bypass", 32'(g_gnt), 32'd0);
      step(1, 0, 0, 0, 0);
      chk("burst_regrant", 32'(g_gnt), 32'd1);
      chk("burst_count", 32'(outstanding_o), 32'd7);

      // Grant and ack together.
      for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 0);
      step(1, 0, 1, 0, 0);
      chk("sim_gnt", 32'(g_gnt), 32'd1);
      chk("sim_cnt", 32'(outstanding_o), 32'd3);
      for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0);
      step(1, 0, 1, 0, 0);
      chk("sim_full_gnt", 32'(g_gnt), 32'd0);
      chk("sim_full_cnt", 32'(outstanding_o), 32'd6);

      // Non-idempotent store waits for an empty pipe, then blocks others.
      for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 0);
      step(1, 1, 0, 0, 0);
      chk("ni_held", 32'(g_gnt), 32'd0);
      step(1, 1, 1, 0, 0);
      step(1, 1, 1, 0, 0);
      step(1, 1, 0, 0, 0);
      chk("ni_gnt", 32'(g_gnt), 32'd1);
      step(1, 0, 0, 0, 0);
      chk("ni_block", 32'(g_gnt), 32'd0);
      step(1, 0, 1, 0, 0);
      chk("ni_block_ack", 32'(g_gnt), 32'd0);
      step(1, 0, 0, 0, 0);
      chk("ni_after", 32'(g_gnt), 32'd1);

      // Fence drains four stores and pulses done exactly once.
      for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0);
      done_total = 0;
      step(1, 0, 0, 1, 0);
      step(1, 0, 0, 1, 0);
      chk("fence_blocks", 32'(g_gnt), 32'd0);
      for (int i = 0; i < 4; i++) step(1, 0, 1, 1, 0);
      step(0, 0, 0, 1, 0);
      chk("fence_done", 32'(g_done), 32'd1);
      step(0, 0, 0, 0, 0);
      chk("fence_once", 32'(done_total), 32'd1);
      step(0, 0, 0, 1, 0);
      chk("fence0_not_yet", 32'(g_done), 32'd0);
      step(0, 0, 0, 1, 0);
      chk("fence0_lat1", 32'(g_done), 32'd1);
      step(0, 0, 0, 0, 0);

      // Flush aborts a drain without a done pulse and keeps the count.
      for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0);
      done_total = 0;
      step(0, 0, 0, 1, 0);
      step(0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 1);
      chk("flush_cnt", 32'(outstanding_o), 32'd3);
      step(1, 0, 0, 0, 0);
      chk("flush_resume", 32'(g_gnt), 32'd1);
      chk("flush_no_done", 32'(done_total), 32'd0);

      // Reset in the middle of a drain.
      step(0, 0, 0, 1, 0);
      do_reset(1'b1);

      // Spurious ack at zero sets the sticky error.
      step(0, 0, 1, 0, 0);
      step(0, 0, 0, 0, 0);
      chk("err_sticky", 32'(ack_err_o), 32'd1);
      chk("err_cnt", 32'(outstanding_o), 32'd0);
      step(1, 0, 0, 0, 0);
      chk("err_still", 32'(ack_err_o), 32'd1);
      do_reset(1'b0);

      // Randomized traffic with a well-behaved fence requester.
      f_lvl = 1'b0;
      g_done = 1'b0;
      for (int i = 0; i < 800; i++) begin
         if (g_done) f_lvl = 1'b0;
         else if (!f_lvl && $urandom_range(0, 15) == 0) f_lvl = 1'b1;
         fl = ($urandom_range(0, 39) == 0);
         if (fl && $urandom_range(0, 1) == 1) f_lvl = 1'b0;
         rq = ($urandom_range(0, 1) == 1);
         nq = ($urandom_range(0, 7) == 0);
         ak = (m_cnt > 0) && ($urandom_range(0, 2) == 0);
         step(rq, nq, ak, f_lvl, fl);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
